// File: rtl/pwm_deadtime_gen.sv
// Complementary gate-drive generator with programmable dead time and latched fault shutdown.
// Every gate output is a flop, so no input can reach hs/ls combinationally.
module pwm_deadtime_gen #(
    parameter int CHANNELS = 3,
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [DT_WIDTH-1:0] dead_time_i,
    input  logic [CHANNELS-1:0] pwm_in_i,
    input  logic                fault_i,
    input  logic                fault_clr_i,
    output logic [CHANNELS-1:0] hs_out_o,
    output logic [CHANNELS-1:0] ls_out_o,
    output logic                fault_latched_o
);

    typedef enum logic [2:0] {
        OFF,
        LOW_ON,
        DT_RISE,
        HIGH_ON,
        DT_FALL
    } state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] pwm_q;
    logic [CHANNELS-1:0] hs_q;
    logic [CHANNELS-1:0] ls_q;
    logic                fault_q;
    logic                fault_latched_q;
    logic                fault_latched_d;

    // A fault still present in the input register overrides a clear request.
    always_comb begin
        fault_latched_d = fault_latched_q;
        if (fault_q) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr_i) begin
            fault_latched_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (fault_latched_q || fault_q || !enable_i) begin
                state_d[i] = OFF;
            end else begin
                case (state_q[i])
                    OFF: begin
                        state_d[i] = pwm_q[i] ? HIGH_ON : LOW_ON;
                    end
                    LOW_ON: begin
                        if (pwm_q[i]) begin
                            if (dead_time_i == '0) begin
                                state_d[i] = HIGH_ON;
                            end else begin
                                state_d[i] = DT_RISE;
                                cnt_d[i]   = dead_time_i - DT_WIDTH'(1);
                            end
                        end
                    end
                    // Dropping pwm during the gap abandons the edge, so a short pulse never reaches hs.
                    DT_RISE: begin
                        if (!pwm_q[i]) begin
                            state_d[i] = LOW_ON;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = HIGH_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
                        end
                    end
                    HIGH_ON: begin
                        if (!pwm_q[i]) begin
                            if (dead_time_i == '0) begin
                                state_d[i] = LOW_ON;
                            end else begin
                                state_d[i] = DT_FALL;
                                cnt_d[i]   = dead_time_i - DT_WIDTH'(1);
                            end
                        end
                    end
                    DT_FALL: begin
                        if (pwm_q[i]) begin
                            state_d[i] = HIGH_ON;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = LOW_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d[i] = OFF;
                    end
                endcase
            end
        end
    end

    // Gate flops are loaded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q           <= '0;
            fault_q         <= 1'b0;
            fault_latched_q <= 1'b0;
            hs_q            <= '0;
            ls_q            <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            pwm_q           <= pwm_in_i;
            fault_q         <= fault_i;
            fault_latched_q <= fault_latched_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hs_q[i]    <= (state_d[i] == HIGH_ON);
                ls_q[i]    <= (state_d[i] == LOW_ON);
            end
        end
    end

    assign hs_out_o        = hs_q;
    assign ls_out_o        = ls_q;
    assign fault_latched_o = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: dead-time gaps, pulse suppression, fault latch,
// enable/reset behaviour, plus a random run guarded by a per-cycle overlap check.
module tb_pwm_deadtime_gen;

    localparam int CH = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] deadTime;
    logic [CH-1:0] pwmIn;
    logic          fault;
    logic          faultClr;
    logic [CH-1:0] hs;
    logic [CH-1:0] ls;
    logic          faultLatched;

    int compared   = 0;
    int mismatched = 0;

    pwm_deadtime_gen #(.CHANNELS(CH), .DT_WIDTH(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable),
        .dead_time_i     (deadTime),
        .pwm_in_i        (pwmIn),
        .fault_i         (fault),
        .fault_clr_i     (faultClr),
        .hs_out_o        (hs),
        .ls_out_o        (ls),
        .fault_latched_o (faultLatched)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [DW-1:0] dt, input logic [CH-1:0] pwm,
                                 input logic flt, input logic clr);
        enable   = en;
        deadTime = dt;
        pwmIn    = pwm;
        fault    = flt;
        faultClr = clr;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkGates(input string tag, input logic [CH-1:0] expHs, input logic [CH-1:0] expLs);
        checkOutput({tag, " hs"}, 32'(hs), 32'(expHs));
        checkOutput({tag, " ls"}, 32'(ls), 32'(expLs));
    endtask

    // {hs,ls} of the pulsed channel after edge t+m, for a pulse of w cycles starting from LOW_ON.
    function automatic logic [1:0] pulseExpect(input int m, input int w, input int dt);
        if (m <= 0) return 2'b01;
        if (dt == 0) return (m <= w) ? 2'b10 : 2'b01;
        if (w <= dt) return (m <= w) ? 2'b00 : 2'b01;
        if (m <= dt) return 2'b00;
        if (m <= w) return 2'b10;
        if (m <= w + dt) return 2'b00;
        return 2'b01;
    endfunction

    task automatic runPulse(input int ch, input int w, input int dt, input string tag);
        logic [CH-1:0] pwm;
        logic [CH-1:0] expHs;
        logic [CH-1:0] expLs;
        logic [1:0]    e;
        pwm     = '0;
        pwm[ch] = 1'b1;
        applyStimulus(1'b1, DW'(dt), pwm, 1'b0, 1'b0);
        for (int m = 0; m < w + dt + 4; m++) begin
            tick(1);
            e         = pulseExpect(m, w, dt);
            expHs     = '0;
            expHs[ch] = e[1];
            expLs     = '1;
            expLs[ch] = e[0];
            checkGates($sformatf("%s m=%0d", tag, m), expHs, expLs);
            if (m == w - 1) applyStimulus(1'b1, DW'(dt), '0, 1'b0, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("overlap", 32'(hs & ls), 32'd0);
    end

    initial begin
        logic [CH-1:0] expHs;
        logic [CH-1:0] expLs;
        logic          p;

        rst_n = 1'b0;
        applyStimulus(1'b1, 8'd4, '0, 1'b0, 1'b0);
        tick(2);
        checkGates("reset", '0, '0);
        checkOutput("reset fault_latched", 32'(faultLatched), 32'd0);
        rst_n = 1'b1;
        tick(2);
        checkGates("release", 3'b000, 3'b111);
        checkOutput("release fault_latched", 32'(faultLatched), 32'd0);

        runPulse(0, 20, 4, "dt4 w20");
        runPulse(2, 5, 5, "dt5 w5");
        runPulse(2, 8, 5, "dt5 w8");
        runPulse(1, 1, 0, "dt0 w1");

        // dt=0, ch1 toggles every 3 cycles: gates follow pwm one edge later with no gap.
        applyStimulus(1'b1, 8'd0, 3'b010, 1'b0, 1'b0);
        for (int m = 0; m < 18; m++) begin
            tick(1);
            p = (m == 0) ? 1'b0 : (((m - 1) / 3) % 2 == 0);
            checkGates($sformatf("toggle m=%0d", m), {1'b0, p, 1'b0}, {1'b1, ~p, 1'b1});
            applyStimulus(1'b1, 8'd0, {1'b0, (((m + 1) / 3) % 2 == 0), 1'b0}, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'd0, '0, 1'b0, 1'b0);
        tick(3);
        checkGates("toggle end", 3'b000, 3'b111);

        // Fault latch sequence with ch0 in HIGH_ON.
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b0, 1'b0);
        tick(10);
        checkGates("prefault", 3'b001, 3'b110);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b1, 1'b0);
        tick(1);
        checkGates("fault edge1", 3'b001, 3'b110);
        checkOutput("fault edge1 latched", 32'(faultLatched), 32'd0);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b0, 1'b0);
        tick(1);
        checkGates("fault edge2", 3'b000, 3'b000);
        checkOutput("fault edge2 latched", 32'(faultLatched), 32'd1);
        tick(1);
        checkGates("fault hold", 3'b000, 3'b000);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b1, 1'b1);
        tick(1);
        checkOutput("clr with fault", 32'(faultLatched), 32'd1);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b0, 1'b0);
        tick(1);
        checkOutput("no clr", 32'(faultLatched), 32'd1);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b0, 1'b1);
        tick(1);
        checkOutput("clr", 32'(faultLatched), 32'd0);
        checkGates("clr edge", 3'b000, 3'b000);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b0, 1'b0);
        tick(1);
        checkGates("resume", 3'b001, 3'b110);

        // dead_time 8 -> 2 while DT_RISE is running: gap stays 8, next gap is 2.
        applyStimulus(1'b1, 8'd8, 3'b000, 1'b0, 1'b0);
        tick(14);
        checkGates("dtchg pre", 3'b000, 3'b111);
        applyStimulus(1'b1, 8'd8, 3'b001, 1'b0, 1'b0);
        for (int m = 0; m < 17; m++) begin
            tick(1);
            if (m == 0 || m >= 15) begin
                expHs = 3'b000; expLs = 3'b111;
            end else if (m <= 8 || m == 13 || m == 14) begin
                expHs = 3'b000; expLs = 3'b110;
            end else begin
                expHs = 3'b001; expLs = 3'b110;
            end
            checkGates($sformatf("dtchg m=%0d", m), expHs, expLs);
            if (m == 2) applyStimulus(1'b1, 8'd2, 3'b001, 1'b0, 1'b0);
            if (m == 11) applyStimulus(1'b1, 8'd2, 3'b000, 1'b0, 1'b0);
        end

        // enable dropped during DT_RISE.
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b0, 1'b0);
        tick(2);
        checkGates("en dt", 3'b000, 3'b110);
        applyStimulus(1'b0, 8'd4, 3'b001, 1'b0, 1'b0);
        tick(1);
        checkGates("en off", 3'b000, 3'b000);
        applyStimulus(1'b1, 8'd4, 3'b001, 1'b0, 1'b0);
        tick(1);
        checkGates("en resume", 3'b001, 3'b110);
        applyStimulus(1'b1, 8'd4, 3'b000, 1'b0, 1'b0);
        tick(8);
        checkGates("en settle", 3'b000, 3'b111);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkGates("async reset", 3'b000, 3'b000);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        checkGates("after async", 3'b000, 3'b111);

        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 9) != 0, DW'($urandom_range(0, 6)), CH'($urandom_range(0, 7)),
                          $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0);
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream stage of the 3-channel PWM generator. It consumes the raw per-channel PWM waveforms and produces complementary high-side/low-side gate-drive pairs.
- Inserts a programmable dead time so that hs_out and ls_out are never both high.
- Provides a latched fault shutdown that forces all gate outputs low.
- All outputs are decoded from registered state only: glitch-free, no combinational input-to-output path.

Parameters:
CHANNELS, 3, number of PWM channels / gate pairs
DT_WIDTH, 8, width of dead_time, in clk cycles

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  global output enable; 0 forces all channels to OFF
dead_time  input  DT_WIDTH  dead-time length in clk cycles, shared by all channels
pwm_in  input  CHANNELS  raw PWM from the PWM generator, synchronous to clk
fault  input  1  external fault, active-high, synchronous to clk
fault_clr  input  1  single-cycle pulse that clears the fault latch
hs_out  output  CHANNELS  high-side gate drive
ls_out  output  CHANNELS  low-side gate drive
fault_latched  output  1  sticky fault status

Behaviour:
- Reset: all channel FSMs in OFF; hs_out=0, ls_out=0, fault_latched=0. Input registers pwm_q=0, fault_q=0. Dead-time counters = 0.
- Input stage: pwm_q and fault_q register pwm_in and fault every cycle.
- Fault latch:
  - fault_latched sets on the cycle after fault_q=1.
  - It clears when fault_clr=1 and fault_q=0.
  - If fault_q=1 and fault_clr=1 in the same cycle, the latch stays set.
- Per-channel FSM states and outputs (hs, ls):
  - OFF (0,0)
  - LOW_ON (0,1)
  - DT_RISE (0,0)
  - HIGH_ON (1,0)
  - DT_FALL (0,0)
- Priority, evaluated every cycle:
  1. fault_latched=1 or fault_q=1 -> OFF.
  2. Otherwise enable=0 -> OFF.
  3. Otherwise normal transitions.
- Normal transitions:
  - OFF: pwm_q=1 -> HIGH_ON; pwm_q=0 -> LOW_ON. Both switches were off, so no dead time is needed.
  - LOW_ON:
    - pwm_q=1 and dead_time=0 -> HIGH_ON.
    - pwm_q=1 and dead_time>0 -> DT_RISE, cnt <= dead_time-1.
  - DT_RISE:
    - pwm_q=0 -> LOW_ON. This suppresses a short pulse; hs never asserts.
    - Else cnt=0 -> HIGH_ON.
    - Else cnt <= cnt-1.
  - HIGH_ON: mirror of LOW_ON with pwm_q=0 -> DT_FALL or LOW_ON.
  - DT_FALL: mirror of DT_RISE. pwm_q=1 returns to HIGH_ON; cnt=0 -> LOW_ON.
- Dead-time loading: dead_time is sampled only on entry to DT_RISE/DT_FALL. A change mid-interval does not affect the running interval.
- Timing:
  - pwm_in edge sampled at clock edge t -> pwm_q valid after t -> FSM leaves LOW_ON/HIGH_ON at edge t+1.
  - The both-low gap is exactly dead_time cycles.
  - The opposite gate asserts at edge t+1+dead_time.
- Pulse and period boundaries:
  - A pwm_in pulse of width W cycles with W <= dead_time produces no opposite-side pulse.
  - Width W > dead_time produces W-dead_time cycles on the opposite side.
  - pwm_in constant 1 (100 % duty) -> HIGH_ON indefinitely. Constant 0 -> LOW_ON.
- Fault latency: fault high before edge t -> fault_q=1 after t -> all outputs 0 after edge t+1, from any state including DT.
- Leaving fault/disable: resume through the OFF rules on the cycle after the condition clears.
- Invariant: hs_out[i] & ls_out[i] = 0 in every cycle, including reset deassertion and mid-operation reset.
- Mid-operation reset: asynchronous; outputs drop to 0 immediately, independent of clk.

Test Plan:
- Reset release, enable=1, pwm_in=0 -> ls_out=3'b111, hs_out=0 two cycles after release; fault_latched=0.
- dead_time=4; ch0 pwm_in 0->1 held 20 cycles, then 1->0 -> ls_out[0] falls at edge t+1; both low for exactly 4 cycles; hs_out[0] high 16 cycles; both low for 4 cycles; ls_out[0] returns.
- dead_time=0; ch1 toggling every 3 cycles -> hs/ls swap at edge t+1 with no gap and never overlap.
- dead_time=5; ch2 pulse of 5 cycles -> hs_out[2] never asserts, ls_out[2] low 5 cycles. Pulse of 8 cycles -> hs_out[2] high 3 cycles.
- Fault: fault=1 for 1 cycle while ch0 is in HIGH_ON -> all outputs 0 two edges later, fault_latched=1. fault_clr with fault=1 -> stays latched. fault_clr with fault=0 -> cleared; channels restart via OFF to LOW_ON or HIGH_ON.
- Change dead_time 8->2 in the middle of a DT_RISE -> the current gap is still 8 cycles and the next gap is 2. enable=0 mid-DT -> OFF next cycle. Random pwm_in/enable/fault stress -> assertion hs&ls==0 never fires.
